cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) between the ALU result path and the memory-unit result path. Each source writes into its own small FIFO. A round-robin arbiter drains one entry per cycle onto a registered CDB. The CDB drives the reservation station's tag-match/wakeup inputs, so exactly one (tag, data) pair is broadcast per cycle.

Parameters:
DATA_W, 32, width of result data
TAG_W, 3, width of destination tag; tag 0 means "no tag"
DEPTH, 2, entries per source FIFO; power of two, >= 2

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-low reset (reset when rst==0 at posedge)
flush  in  1  synchronous pipeline flush (branch mispredict)
alu_valid  in  1  ALU result present
alu_des  in  TAG_W  ALU destination tag
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU FIFO can accept this cycle
mem_valid  in  1  memory result present
mem_des  in  TAG_W  memory destination tag
mem_data  in  DATA_W  memory result
mem_ready  out  1  memory FIFO can accept this cycle
cdb_valid  out  1  broadcast valid
cdb_des  out  TAG_W  broadcast tag; 0 when not valid
cdb_data  out  DATA_W  broadcast data
alu_cnt  out  clog2(DEPTH)+1  ALU FIFO occupancy
mem_cnt  out  clog2(DEPTH)+1  memory FIFO occupancy

Behaviour:
- Reset (rst==0 at posedge):
  - both FIFOs are emptied (pointers and counts = 0).
  - cdb_valid=0, cdb_des=0, cdb_data=0.
  - last_grant=MEM, so the ALU wins the first contested arbitration.
  - Reset overrides flush and all pushes.
- Ready:
  - alu_ready = (alu_cnt != DEPTH); mem_ready likewise.
  - Both are combinational from registered counts only; they do not depend on a same-cycle pop.
  - A full FIFO therefore never accepts, even when it is popped that cycle.
- Push:
  - Occurs at posedge when valid && ready && des != 0 && !flush.
  - valid with des==0 is silently dropped and does not change any count.
  - A push into a full FIFO is ignored; the source must hold valid.
- Arbitration, evaluated every cycle on FIFO state before this edge's pushes:
  - Both FIFOs empty: no grant.
  - Exactly one non-empty: grant that FIFO.
  - Both non-empty: grant the source that is not last_grant; last_grant updates on every grant.
- Pop and broadcast:
  - The granted FIFO pops its head at the posedge.
  - At the same posedge cdb_valid<=1, cdb_des<=head tag, cdb_data<=head data.
  - With no grant: cdb_valid<=0 and cdb_des<=0; cdb_data holds its last value.
- Latency: a result pushed at edge k is broadcast no earlier than edge k+1, visible after k+1. There is no same-cycle bypass.
- Simultaneous push and pop on the same FIFO: count is unchanged and pointers advance normally.
- Wrap-around: read and write pointers wrap modulo DEPTH. Counts never exceed DEPTH or underflow.
- Flush (rst==1, flush==1 at posedge):
  - both FIFOs are emptied; inputs that cycle are ignored.
  - cdb_valid<=0, cdb_des<=0.
  - last_grant is unchanged.
  - The next cycle operates normally.
- Fairness: under continuous contention grants strictly alternate, so a source waits at most one cycle for the CDB.
- Ordering: entries from the same source broadcast in FIFO order. There is no ordering guarantee across sources.

Test Plan:
- Reset then idle: drive rst=0 for 2 cycles, then rst=1 with no valids -> cdb_valid=0, cdb_des=0, cdb_data=0, alu_ready=mem_ready=1, counts 0.
- Single ALU result: alu_valid=1, alu_des=3, alu_data=0x12345678 for one cycle -> after the next edge cdb_valid=1, cdb_des=3, cdb_data=0x12345678; one cycle later cdb_valid=0, cdb_des=0.
- Contention: push ALU (tag 1, 0xA) and MEM (tag 5, 0xB) on the same edge, twice, with tags 2/6 the second time -> broadcast order tag 1, 5, 2, 6 on four consecutive cycles.
- Backpressure and wrap (DEPTH=2): hold mem_valid=1 for 5 cycles with tags 1..5 while ALU floods constantly -> mem_ready drops at mem_cnt=2 and the source holds. All 5 MEM tags appear in order. No MEM gap exceeds one ALU broadcast.
- Tag 0 and flush:
  - alu_valid=1, alu_des=0 -> no count change, no broadcast.
  - Fill both FIFOs, then flush=1 with alu_valid=1 -> both counts 0 next cycle, cdb_valid=0, the flushed-cycle input is not broadcast.
- Reset mid-operation: both FIFOs full and cdb_valid=1, then rst=0 for one edge -> all counts 0, cdb outputs 0, and the first contested grant afterwards goes to the ALU.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two small per-source result FIFOs drained
// round-robin, one (tag, data) pair per cycle, onto a registered CDB.

module cdb_fifo #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 3,
   parameter int DEPTH  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    push,
   input  logic [TAG_W-1:0]        push_tag,
   input  logic [DATA_W-1:0]       push_data,
   input  logic                    pop,
   output logic [TAG_W-1:0]        head_tag,
   output logic [DATA_W-1:0]       head_data,
   output logic [$clog2(DEPTH):0]  cnt,
   output logic                    ready,
   output logic                    not_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [TAG_W-1:0]  tag_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;

   // Storage needs no reset: pointers and count decide what is live.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_mem[wptr]  <= push_tag;
         data_mem[wptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_W'(1);
         if (pop)  rptr <= rptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_comb begin
      head_tag  = tag_mem[rptr];
      head_data = data_mem[rptr];
      ready     = (cnt != FULL);
      not_empty = (cnt != '0);
   end

endmodule

module cdb_arbiter #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 3,
   parameter int DEPTH  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    alu_valid,
   input  logic [TAG_W-1:0]        alu_des,
   input  logic [DATA_W-1:0]       alu_data,
   output logic                    alu_ready,
   input  logic                    mem_valid,
   input  logic [TAG_W-1:0]        mem_des,
   input  logic [DATA_W-1:0]       mem_data,
   output logic                    mem_ready,
   output logic                    cdb_valid,
   output logic [TAG_W-1:0]        cdb_des,
   output logic [DATA_W-1:0]       cdb_data,
   output logic [$clog2(DEPTH):0]  alu_cnt,
   output logic [$clog2(DEPTH):0]  mem_cnt
);

   typedef enum logic {SRC_ALU, SRC_MEM} src_t;

   src_t              last_grant;
   logic              alu_push, mem_push;
   logic              alu_ne, mem_ne;
   logic              grant_alu, grant_mem;
   logic [TAG_W-1:0]  alu_head_tag, mem_head_tag;
   logic [DATA_W-1:0] alu_head_data, mem_head_data;

   // Tag 0 means "no destination", so such results never enter a FIFO.
   always_comb begin
      alu_push = alu_valid && alu_ready && (alu_des != '0) && !flush;
      mem_push = mem_valid && mem_ready && (mem_des != '0) && !flush;
   end

   cdb_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_alu_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (alu_push),
      .push_tag  (alu_des),
      .push_data (alu_data),
      .pop       (grant_alu),
      .head_tag  (alu_head_tag),
      .head_data (alu_head_data),
      .cnt       (alu_cnt),
      .ready     (alu_ready),
      .not_empty (alu_ne)
   );

   cdb_fifo #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_mem_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (mem_push),
      .push_tag  (mem_des),
      .push_data (mem_data),
      .pop       (grant_mem),
      .head_tag  (mem_head_tag),
      .head_data (mem_head_data),
      .cnt       (mem_cnt),
      .ready     (mem_ready),
      .not_empty (mem_ne)
   );

   // Under contention the source that did not win last time goes next.
   always_comb begin
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      if (alu_ne && mem_ne) begin
         if (last_grant == SRC_MEM) grant_alu = 1'b1;
         else                       grant_mem = 1'b1;
      end else if (alu_ne) begin
         grant_alu = 1'b1;
      end else if (mem_ne) begin
         grant_mem = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cdb_valid  <= 1'b0;
         cdb_des    <= '0;
         cdb_data   <= '0;
         last_grant <= SRC_MEM;
      end else if (flush) begin
         cdb_valid  <= 1'b0;
         cdb_des    <= '0;
      end else if (grant_alu) begin
         cdb_valid  <= 1'b1;
         cdb_des    <= alu_head_tag;
         cdb_data   <= alu_head_data;
         last_grant <= SRC_ALU;
      end else if (grant_mem) begin
         cdb_valid  <= 1'b1;
         cdb_des    <= mem_head_tag;
         cdb_data   <= mem_head_data;
         last_grant <= SRC_MEM;
      end else begin
         cdb_valid  <= 1'b0;
         cdb_des    <= '0;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.

module tb_cdb_arbiter;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 3;
   localparam int DEPTH  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              alu_valid;
   logic [TAG_W-1:0]  alu_des;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              mem_valid;
   logic [TAG_W-1:0]  mem_des;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_des;
   logic [DATA_W-1:0] cdb_data;
   logic [$clog2(DEPTH):0] alu_cnt;
   logic [$clog2(DEPTH):0] mem_cnt;

   int checks = 0;
   int errors = 0;
   bit model_en = 1'b0;

   cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .alu_valid (alu_valid),
      .alu_des   (alu_des),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .mem_valid (mem_valid),
      .mem_des   (mem_des),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .cdb_valid (cdb_valid),
      .cdb_des   (cdb_des),
      .cdb_data  (cdb_data),
      .alu_cnt   (alu_cnt),
      .mem_cnt   (mem_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: each FIFO is a plain queue; the CDB is what was popped.
   logic [TAG_W-1:0]  aq_tag [$];
   logic [DATA_W-1:0] aq_dat [$];
   logic [TAG_W-1:0]  mq_tag [$];
   logic [DATA_W-1:0] mq_dat [$];
   bit                m_last_mem = 1'b1;
   logic              m_valid = 1'b0;
   logic [TAG_W-1:0]  m_des = '0;
   logic [DATA_W-1:0] m_data = '0;

   always @(posedge clk) begin
      int  an;
      int  mn;
      bit  ga;
      bit  gm;
      an = aq_tag.size();
      mn = mq_tag.size();
      if (rst === 1'b0) begin
         aq_tag.delete(); aq_dat.delete(); mq_tag.delete(); mq_dat.delete();
         m_valid = 1'b0; m_des = '0; m_data = '0; m_last_mem = 1'b1;
      end else if (flush) begin
         aq_tag.delete(); aq_dat.delete(); mq_tag.delete(); mq_dat.delete();
         m_valid = 1'b0; m_des = '0;
      end else begin
         ga = (an > 0) && ((mn == 0) || m_last_mem);
         gm = (mn > 0) && !ga;
         if (ga) begin
            m_valid = 1'b1; m_des = aq_tag.pop_front(); m_data = aq_dat.pop_front();
            m_last_mem = 1'b0;
         end else if (gm) begin
            m_valid = 1'b1; m_des = mq_tag.pop_front(); m_data = mq_dat.pop_front();
            m_last_mem = 1'b1;
         end else begin
            m_valid = 1'b0; m_des = '0;
         end
         if (alu_valid && an < DEPTH && alu_des != '0) begin
            aq_tag.push_back(alu_des); aq_dat.push_back(alu_data);
         end
         if (mem_valid && mn < DEPTH && mem_des != '0) begin
            mq_tag.push_back(mem_des); mq_dat.push_back(mem_data);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_en) begin
         checkOutput("m_cdb_valid", 64'(cdb_valid), 64'(m_valid));
         checkOutput("m_cdb_des",   64'(cdb_des),   64'(m_des));
         checkOutput("m_cdb_data",  64'(cdb_data),  64'(m_data));
         checkOutput("m_alu_cnt",   64'(alu_cnt),   64'(aq_tag.size()));
         checkOutput("m_mem_cnt",   64'(mem_cnt),   64'(mq_tag.size()));
         checkOutput("m_alu_ready", 64'(alu_ready), 64'(aq_tag.size() != DEPTH));
         checkOutput("m_mem_ready", 64'(mem_ready), 64'(mq_tag.size() != DEPTH));
      end
   end

   task automatic applyStimulus(input logic av, input logic [TAG_W-1:0] ad,
                                input logic [DATA_W-1:0] adat, input logic mv,
                                input logic [TAG_W-1:0] md, input logic [DATA_W-1:0] mdat,
                                input logic fl);
      alu_valid = av; alu_des = ad; alu_data = adat;
      mem_valid = mv; mem_des = md; mem_data = mdat;
      flush = fl;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   initial begin
      int  mtag;
      int  seen;
      int  alu_since;
      int  max_gap;
      bit  saw_not_ready;
      bit  order_ok;
      bit  will_accept;
      bit  push_mem;

      rst = 1'b0; flush = 1'b0;
      alu_valid = 1'b0; alu_des = '0; alu_data = '0;
      mem_valid = 1'b0; mem_des = '0; mem_data = '0;

      // Reset then idle
      idle();
      model_en = 1'b1;
      idle();
      rst = 1'b1;
      idle();
      checkOutput("rst_cdb_valid", 64'(cdb_valid), 64'd0);
      checkOutput("rst_cdb_des",   64'(cdb_des),   64'd0);
      checkOutput("rst_cdb_data",  64'(cdb_data),  64'd0);
      checkOutput("rst_alu_ready", 64'(alu_ready), 64'd1);
      checkOutput("rst_mem_ready", 64'(mem_ready), 64'd1);
      checkOutput("rst_alu_cnt",   64'(alu_cnt),   64'd0);
      checkOutput("rst_mem_cnt",   64'(mem_cnt),   64'd0);

      // Single ALU result: no bypass, broadcast one edge later
      applyStimulus(1'b1, 3'd3, 32'h12345678, 1'b0, '0, '0, 1'b0);
      checkOutput("single_nobypass", 64'(cdb_valid), 64'd0);
      idle();
      checkOutput("single_valid", 64'(cdb_valid), 64'd1);
      checkOutput("single_des",   64'(cdb_des),   64'd3);
      checkOutput("single_data",  64'(cdb_data),  64'h12345678);
      idle();
      checkOutput("single_after_valid", 64'(cdb_valid), 64'd0);
      checkOutput("single_after_des",   64'(cdb_des),   64'd0);
      checkOutput("single_data_hold",   64'(cdb_data),  64'h12345678);

      // Contention from a fresh reset: ALU wins first
      rst = 1'b0; idle(); rst = 1'b1;
      applyStimulus(1'b1, 3'd1, 32'hA, 1'b1, 3'd5, 32'hB, 1'b0);
      applyStimulus(1'b1, 3'd2, 32'hA2, 1'b1, 3'd6, 32'hB2, 1'b0);
      checkOutput("cont_des0",  64'(cdb_des),  64'd1);
      checkOutput("cont_data0", 64'(cdb_data), 64'hA);
      idle();
      checkOutput("cont_des1",  64'(cdb_des),  64'd5);
      checkOutput("cont_data1", 64'(cdb_data), 64'hB);
      idle();
      checkOutput("cont_des2",  64'(cdb_des),  64'd2);
      idle();
      checkOutput("cont_des3",  64'(cdb_des),  64'd6);
      idle();
      checkOutput("cont_drained", 64'(cdb_valid), 64'd0);

      // Backpressure and wrap: MEM tags 1..5 against a constant ALU flood (tag 7)
      mtag = 1; seen = 0; alu_since = 0; max_gap = 0;
      saw_not_ready = 1'b0; order_ok = 1'b1;
      for (int cyc = 0; cyc < 80 && seen < 5; cyc++) begin
         if (!mem_ready) saw_not_ready = 1'b1;
         push_mem = (mtag <= 5);
         will_accept = push_mem && mem_ready;
         applyStimulus(1'b1, 3'd7, 32'(cyc), push_mem, 3'(mtag), 32'hB000 + 32'(mtag), 1'b0);
         if (will_accept) mtag++;
         if (cdb_valid) begin
            if (cdb_des == 3'd7) alu_since++;
            else begin
               seen++;
               if (32'(cdb_des) != 32'(seen)) order_ok = 1'b0;
               if (seen > 1 && alu_since > max_gap) max_gap = alu_since;
               alu_since = 0;
            end
         end
      end
      checkOutput("bp_all_seen",  64'(seen), 64'd5);
      checkOutput("bp_order",     64'(order_ok), 64'd1);
      checkOutput("bp_max_gap",   64'(max_gap <= 1), 64'd1);
      checkOutput("bp_not_ready", 64'(saw_not_ready), 64'd1);
      repeat (6) idle();

      // Tag 0 is dropped
      applyStimulus(1'b1, 3'd0, 32'hDEAD, 1'b0, '0, '0, 1'b0);
      checkOutput("tag0_cnt", 64'(alu_cnt), 64'd0);
      idle();
      checkOutput("tag0_nobcast", 64'(cdb_valid), 64'd0);

      // Flush with both FIFOs loaded
      applyStimulus(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22, 1'b0);
      applyStimulus(1'b1, 3'd3, 32'h33, 1'b1, 3'd4, 32'h44, 1'b0);
      applyStimulus(1'b1, 3'd5, 32'h55, 1'b1, 3'd6, 32'h66, 1'b0);
      applyStimulus(1'b1, 3'd5, 32'hF1, 1'b1, 3'd6, 32'hF2, 1'b1);
      checkOutput("flush_alu_cnt", 64'(alu_cnt), 64'd0);
      checkOutput("flush_mem_cnt", 64'(mem_cnt), 64'd0);
      checkOutput("flush_valid",   64'(cdb_valid), 64'd0);
      checkOutput("flush_des",     64'(cdb_des), 64'd0);
      idle();
      checkOutput("flush_no_bcast", 64'(cdb_valid), 64'd0);

      // Reset mid-operation
      repeat (4) applyStimulus(1'b1, 3'd4, 32'h77, 1'b1, 3'd5, 32'h88, 1'b0);
      checkOutput("mid_busy", 64'(cdb_valid), 64'd1);
      rst = 1'b0;
      applyStimulus(1'b1, 3'd4, 32'h77, 1'b1, 3'd5, 32'h88, 1'b0);
      rst = 1'b1;
      checkOutput("mid_alu_cnt", 64'(alu_cnt), 64'd0);
      checkOutput("mid_mem_cnt", 64'(mem_cnt), 64'd0);
      checkOutput("mid_valid",   64'(cdb_valid), 64'd0);
      checkOutput("mid_des",     64'(cdb_des), 64'd0);
      checkOutput("mid_data",    64'(cdb_data), 64'd0);
      applyStimulus(1'b1, 3'd2, 32'hC2, 1'b1, 3'd3, 32'hC3, 1'b0);
      idle();
      checkOutput("mid_first_grant", 64'(cdb_des), 64'd2);
      repeat (2) idle();

      // Randomized traffic, checked every cycle by the model
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 99) != 0);
         applyStimulus(1'(($urandom_range(0, 3) != 0)), 3'($urandom_range(0, 7)), $urandom,
                       1'(($urandom_range(0, 2) != 0)), 3'($urandom_range(0, 7)), $urandom,
                       1'(($urandom_range(0, 29) == 0)));
      end
      rst = 1'b1;
      repeat (4) idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
